row_skew_buffer: RTL and testbench

- Sits directly downstream of the row FIFO controller in the systolic-array input path.
- Collects the serial words the controller reads out of the input FIFO into one ROW-element column vector.
- Commits each vector into ROW per-row FIFOs.
- Drains those FIFOs into the array rows with a diagonal skew: row r is fed r cycles after row 0. It drives the fifo_array_full vector back to the controller.

---
 rtl/row_skew_buffer.sv | 76 +++++++
 tb/tb_row_skew_buffer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/row_skew_buffer.sv
// row_skew_buffer: assembles serial words into ROW-wide vectors, buffers them in per-row FIFOs
// and drains them into the array with a one-cycle-per-row diagonal skew.
module row_skew_buffer #(
  parameter int ROW = 9,
  parameter int W_DATA = 8,
  parameter int DEPTH = 4,
  localparam int IW = $clog2(ROW) + 1,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [W_DATA-1:0]     i_data,
  input  logic                  i_array_ready,
  output logic [ROW-1:0]        o_fifo_array_full,
  output logic [ROW*W_DATA-1:0] o_row_data,
  output logic [ROW-1:0]        o_row_valid,
  output logic [IW-1:0]         o_wr_idx,
  output logic                  o_overflow
);
  logic [W_DATA-1:0]         mem [ROW][DEPTH];
  logic [(ROW-1)*W_DATA-1:0] acc;
  logic [ROW*W_DATA-1:0]     vec;
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr [ROW];
  logic [CW-1:0]             cnt [ROW];
  logic [ROW-1:1]            tok_q;
  logic [ROW-1:0]            tok;
  logic [ROW-1:0]            pop;
  logic                      commit;
  logic                      push;
  assign vec    = {i_data, acc};
  assign commit = i_wr_en && o_wr_idx == IW'(ROW - 1);
  assign push   = commit && ~|o_fifo_array_full;
  assign tok    = {tok_q, i_array_ready && cnt[0] != '0};
  // Every row shares one write pointer since vectors are always pushed to all rows at once.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_wr_idx   <= '0;
      acc        <= '0;
      wr_ptr     <= '0;
      tok_q      <= '0;
      o_overflow <= 1'b0;
    end else begin
      tok_q <= tok[ROW-2:0];
      if (i_wr_en) o_wr_idx <= commit ? '0 : o_wr_idx + 1'b1;
      if (i_wr_en && !commit) acc[o_wr_idx*W_DATA +: W_DATA] <= i_data;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (commit && !push) o_overflow <= 1'b1;
    end
  for (genvar g = 0; g < ROW; g++) begin : g_row
    logic [CW-1:0] cnt_n;
    assign pop[g] = tok[g] && cnt[g] != '0;
    assign cnt_n  = cnt[g] + CW'(push) - CW'(pop[g]);
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
        cnt[g]                          <= '0;
        rd_ptr[g]                       <= '0;
        o_row_valid[g]                  <= 1'b0;
        o_row_data[g*W_DATA +: W_DATA]  <= '0;
        o_fifo_array_full[g]            <= 1'b0;
      end else begin
        cnt[g]               <= cnt_n;
        rd_ptr[g]            <= rd_ptr[g] + AW'(pop[g]);
        o_row_valid[g]       <= pop[g];
        o_fifo_array_full[g] <= cnt_n == CW'(DEPTH);
        if (pop[g]) o_row_data[g*W_DATA +: W_DATA] <= mem[g][rd_ptr[g]];
      end
    always_ff @(posedge i_clk)
      if (push) mem[g][wr_ptr] <= vec[g*W_DATA +: W_DATA];
    // A token reaching an empty row means the atomic-commit invariant was broken.
    always @(posedge i_clk)
      if (i_rst_n && tok[g]) assert (cnt[g] != '0) else $error("row %0d popped while empty", g);
  end
endmodule

// File: tb/tb_row_skew_buffer.sv
// tb_row_skew_buffer: directed vector table plus hand-written multi-cycle sequences.
module tb_row_skew_buffer;
  logic        i_clk = 0;
  logic        i_rst_n = 0;
  logic        i_wr_en = 0;
  logic [7:0]  i_data = 0;
  logic        i_array_ready = 0;
  logic [3:0]  o_fifo_array_full;
  logic [31:0] o_row_data;
  logic [3:0]  o_row_valid;
  logic [2:0]  o_wr_idx;
  logic        o_overflow;
  int total = 0;
  int passed = 0;
  row_skew_buffer #(.ROW(4), .W_DATA(8), .DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_data(i_data),
    .i_array_ready(i_array_ready), .o_fifo_array_full(o_fifo_array_full),
    .o_row_data(o_row_data), .o_row_valid(o_row_valid), .o_wr_idx(o_wr_idx),
    .o_overflow(o_overflow)
  );
  always #5 i_clk = ~i_clk;
  typedef struct {
    logic        we;
    logic [7:0]  d;
    logic        rdy;
    logic [3:0]  vld;
    logic [3:0]  full;
    logic [2:0]  idx;
    logic        ovf;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl [10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask
  task automatic step(input logic we, input logic [7:0] d, input logic rdy);
    i_wr_en = we;
    i_data = d;
    i_array_ready = rdy;
    @(posedge i_clk);
    #1;
    i_wr_en = 0;
    i_array_ready = 0;
  endtask
  task automatic do_reset();
    i_rst_n = 0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1;
  endtask
  function automatic logic [7:0] elem(input int k, input int r);
    return 8'(16 * (k + 1) + r);
  endfunction
  initial begin
    logic [3:0] ev;
    tbl[0] = '{1'b1, 8'h11, 1'b0, 4'h0, 4'h0, 3'd1, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 4'h0, 4'h0, 3'd2, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 4'h0, 4'h0, 3'd3, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 8'h44, 1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 32'h0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 4'h1, 4'h0, 3'd0, 1'b0, 32'h00000011};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 4'h2, 4'h0, 3'd0, 1'b0, 32'h00002211};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 4'h4, 4'h0, 3'd0, 1'b0, 32'h00332211};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 4'h8, 4'h0, 3'd0, 1'b0, 32'h44332211};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 32'h44332211};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 4'h0, 4'h0, 3'd0, 1'b0, 32'h44332211};
    #2;
    chk("rst_data", o_row_data, 0);
    chk("rst_valid", 32'(o_row_valid), 0);
    chk("rst_full", 32'(o_fifo_array_full), 0);
    chk("rst_ovf", 32'(o_overflow), 0);
    do_reset();
    chk("rst_idx", 32'(o_wr_idx), 0);
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].we, tbl[i].d, tbl[i].rdy);
      chk($sformatf("t%0d_valid", i), 32'(o_row_valid), 32'(tbl[i].vld));
      chk($sformatf("t%0d_full", i), 32'(o_fifo_array_full), 32'(tbl[i].full));
      chk($sformatf("t%0d_idx", i), 32'(o_wr_idx), 32'(tbl[i].idx));
      chk($sformatf("t%0d_ovf", i), 32'(o_overflow), 32'(tbl[i].ovf));
      chk($sformatf("t%0d_data", i), o_row_data, tbl[i].rd);
    end
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < 4; r++) step(1, elem(k, r), 0);
    chk("fill_full", 32'(o_fifo_array_full), 32'hf);
    chk("fill_ovf", 32'(o_overflow), 0);
    for (int r = 0; r < 4; r++) step(1, 8'hEE, 0);
    chk("drop_ovf", 32'(o_overflow), 1);
    chk("drop_full", 32'(o_fifo_array_full), 32'hf);
    chk("drop_idx", 32'(o_wr_idx), 0);
    for (int c = 1; c <= 8; c++) begin
      step(0, 0, c <= 4);
      ev = 0;
      for (int r = 0; r < 4; r++) if (c - 1 - r >= 0 && c - 1 - r <= 3) ev[r] = 1;
      chk($sformatf("drain%0d_valid", c), 32'(o_row_valid), 32'(ev));
      for (int r = 0; r < 4; r++)
        if (ev[r]) chk($sformatf("drain%0d_row%0d", c, r), 32'(o_row_data[r*8 +: 8]), 32'(elem(c - 1 - r, r)));
    end
    chk("drained_full", 32'(o_fifo_array_full), 0);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("drained_novalid", 32'(o_row_valid), 0);
    do_reset();
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < 4; r++) step(1, elem(k, r), 0);
    for (int r = 0; r < 3; r++) step(1, 8'h50 + 8'(r), 0);
    step(1, 8'h53, 1);
    chk("race_ovf", 32'(o_overflow), 1);
    chk("race_full", 32'(o_fifo_array_full), 32'he);
    chk("race_valid", 32'(o_row_valid), 1);
    chk("race_idx", 32'(o_wr_idx), 0);
    step(1, 8'h60, 0);
    chk("race_full1", 32'(o_fifo_array_full), 32'hc);
    step(1, 8'h61, 0);
    step(1, 8'h62, 0);
    chk("race_full3", 32'(o_fifo_array_full), 32'h0);
    step(1, 8'h63, 0);
    chk("accept_full", 32'(o_fifo_array_full), 32'hf);
    for (int c = 1; c <= 7; c++) step(0, 0, c <= 4);
    chk("accept_row0", 32'(o_row_data[7:0]), 32'h60);
    chk("accept_row3", 32'(o_row_data[31:24]), 32'h63);
    do_reset();
    for (int r = 0; r < 4; r++) step(1, 8'h70 + 8'(r), 0);
    step(1, 8'h80, 1);
    chk("pre_rst_valid", 32'(o_row_valid), 1);
    chk("pre_rst_row0", 32'(o_row_data[7:0]), 32'h70);
    step(1, 8'h81, 0);
    chk("pre_rst_idx", 32'(o_wr_idx), 2);
    #2 i_rst_n = 0;
    #1;
    chk("arst_data", o_row_data, 0);
    chk("arst_valid", 32'(o_row_valid), 0);
    chk("arst_full", 32'(o_fifo_array_full), 0);
    chk("arst_idx", 32'(o_wr_idx), 0);
    chk("arst_ovf", 32'(o_overflow), 0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      step(0, 0, 0);
      chk($sformatf("post_rst%0d_valid", c), 32'(o_row_valid), 0);
    end
    step(1, 8'h90, 0);
    chk("fresh_idx", 32'(o_wr_idx), 1);
    for (int r = 1; r < 4; r++) step(1, 8'h90 + 8'(r), 0);
    chk("fresh_commit_idx", 32'(o_wr_idx), 0);
    for (int c = 1; c <= 4; c++) begin
      step(0, 0, c == 1);
      chk($sformatf("fresh%0d_valid", c), 32'(o_row_valid), 32'(1 << (c - 1)));
      chk($sformatf("fresh%0d_data", c), 32'(o_row_data[(c-1)*8 +: 8]), 32'(8'h90 + 8'(c - 1)));
    end
    chk("fresh_all", o_row_data, 32'h93929190);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
